// File: rtl/fm_bus_sched_if.sv
// Register-bus scheduler port bundle: two requester channels plus the strobe bus toward fm_top.
// master = scheduler view, slave = requesters/register-port view.
interface fm_bus_sched_if;
   logic       a_req;
   logic       a_rw;
   logic [5:0] a_addr;
   logic [7:0] a_wdata;
   logic       a_gnt;
   logic       a_rvalid;

   logic       b_req;
   logic       b_rw;
   logic [5:0] b_addr;
   logic [7:0] b_wdata;
   logic       b_gnt;
   logic       b_rvalid;

   logic [7:0] rdata;
   logic       busy;

   logic       RWb;
   logic       CEb;
   logic [5:0] reg_addr;
   logic [7:0] bus_wdata;
   logic [7:0] bus_rdata;

   modport master (
      input  a_req, a_rw, a_addr, a_wdata,
      input  b_req, b_rw, b_addr, b_wdata,
      input  bus_rdata,
      output a_gnt, a_rvalid, b_gnt, b_rvalid,
      output rdata, busy,
      output RWb, CEb, reg_addr, bus_wdata
   );

   modport slave (
      output a_req, a_rw, a_addr, a_wdata,
      output b_req, b_rw, b_addr, b_wdata,
      output bus_rdata,
      input  a_gnt, a_rvalid, b_gnt, b_rvalid,
      input  rdata, busy,
      input  RWb, CEb, reg_addr, bus_wdata
   );
endinterface

// File: rtl/fm_bus_sched.sv
// Round-robin scheduler sharing fm_top's RWb/CEb register strobe bus between requesters A and B,
// with programmable strobe/recovery widths and read-data return to the winner.
module fm_bus_sched #(
   parameter int unsigned STROBE_CYC  = 2,
   parameter int unsigned RECOVER_CYC = 1
) (
   input logic            clk,
   input logic            rst_n,
   fm_bus_sched_if.master bus
);

   localparam int unsigned MaxCyc = (STROBE_CYC > RECOVER_CYC) ? STROBE_CYC : RECOVER_CYC;
   localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

   typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StRecover} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic       rw_q;
   logic [5:0] addr_q;
   logic [7:0] wdata_q;
   logic       owner_q;
   logic       last_q;
   logic [7:0] rdata_q;
   logic       ceb_q, rwb_q;
   logic       a_gnt_q, b_gnt_q, a_rvalid_q, b_rvalid_q;

   logic       cnt_done, arb_slot, win, pick_b;
   logic       win_rw;
   logic [5:0] win_addr;
   logic [7:0] win_wdata;
   logic       sample_rd;
   logic       ceb_d, rwb_d, a_gnt_d, b_gnt_d, a_rvalid_d, b_rvalid_d;

   assign cnt_done = (cnt_q == '0);
   // last_q = 1 means B won last; on a tie the other requester wins.
   assign pick_b   = bus.b_req & (~bus.a_req | ~last_q);
   assign arb_slot = (state_q == StIdle) | ((state_q == StRecover) & cnt_done);
   assign win      = arb_slot & (bus.a_req | bus.b_req);

   assign win_rw    = pick_b ? bus.b_rw    : bus.a_rw;
   assign win_addr  = pick_b ? bus.b_addr  : bus.a_addr;
   assign win_wdata = pick_b ? bus.b_wdata : bus.a_wdata;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (win) state_d = StSetup;
         end
         StSetup: begin
            state_d = StStrobe;
            cnt_d   = CntW'(STROBE_CYC - 1);
         end
         StStrobe: begin
            if (cnt_done) begin
               state_d = StRecover;
               cnt_d   = CntW'(RECOVER_CYC - 1);
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StRecover: begin
            if (cnt_done) state_d = win ? StSetup : StIdle;
            else          cnt_d   = cnt_q - CntW'(1);
         end
         default: state_d = StIdle;
      endcase
   end

   // Bus outputs are computed from the next state so they come straight out of flops.
   always_comb begin
      sample_rd  = (state_q == StStrobe) & cnt_done & rw_q;
      ceb_d      = (state_d != StStrobe);
      rwb_d      = (state_d == StIdle) ? 1'b1 : (win ? win_rw : rw_q);
      a_gnt_d    = win & ~pick_b;
      b_gnt_d    = win & pick_b;
      a_rvalid_d = sample_rd & ~owner_q;
      b_rvalid_d = sample_rd & owner_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rw_q       <= 1'b1;
         addr_q     <= '0;
         wdata_q    <= '0;
         owner_q    <= 1'b0;
         last_q     <= 1'b1;
         rdata_q    <= '0;
         ceb_q      <= 1'b1;
         rwb_q      <= 1'b1;
         a_gnt_q    <= 1'b0;
         b_gnt_q    <= 1'b0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
      end else begin
         if (win) begin
            rw_q    <= win_rw;
            addr_q  <= win_addr;
            wdata_q <= win_rw ? 8'h00 : win_wdata;
            owner_q <= pick_b;
            last_q  <= pick_b;
         end
         if (sample_rd) rdata_q <= bus.bus_rdata;
         ceb_q      <= ceb_d;
         rwb_q      <= rwb_d;
         a_gnt_q    <= a_gnt_d;
         b_gnt_q    <= b_gnt_d;
         a_rvalid_q <= a_rvalid_d;
         b_rvalid_q <= b_rvalid_d;
      end
   end

   assign bus.a_gnt     = a_gnt_q;
   assign bus.b_gnt     = b_gnt_q;
   assign bus.a_rvalid  = a_rvalid_q;
   assign bus.b_rvalid  = b_rvalid_q;
   assign bus.rdata     = rdata_q;
   assign bus.busy      = (state_q != StIdle);
   assign bus.RWb       = rwb_q;
   assign bus.CEb       = ceb_q;
   assign bus.reg_addr  = addr_q;
   assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_fm_bus_sched.sv
// Scoreboard bench for fm_bus_sched: default-parameter instance plus a STROBE_CYC=3/RECOVER_CYC=2
// instance for back-to-back pulse-width checks.
module tb_fm_bus_sched;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fm_bus_sched_if b1 ();
   fm_bus_sched_if b2 ();

   fm_bus_sched dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b1.master)
   );

   fm_bus_sched #(
      .STROBE_CYC  (3),
      .RECOVER_CYC (2)
   ) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b2.master)
   );

   // Register-port model: returns addr ^ 0xA2 while strobed (0x07 -> 0xA5).
   assign b1.bus_rdata = b1.CEb ? 8'h00 : ({2'b00, b1.reg_addr} ^ 8'hA2);
   assign b2.bus_rdata = 8'h00;

   typedef struct {
      logic       owner;
      logic       rw;
      logic [5:0] addr;
      logic [7:0] wdata;
   } gnt_t;

   typedef struct {
      logic       owner;
      logic [7:0] data;
   } rd_t;

   gnt_t gnt_q[$];
   rd_t  rd_q[$];
   gnt_t cur;
   rd_t  rd_exp;
   int   low_len = 0;
   int   low2 = 0, gap2 = 0, pulses2 = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_gnt(input logic owner, input logic rw, input logic [5:0] addr,
                           input logic [7:0] wdata);
      gnt_t g;
      g.owner = owner;
      g.rw    = rw;
      g.addr  = addr;
      g.wdata = wdata;
      gnt_q.push_back(g);
   endtask

   task automatic push_rd(input logic owner, input logic [7:0] data);
      rd_t r;
      r.owner = owner;
      r.data  = data;
      rd_q.push_back(r);
   endtask

   // Scoreboard monitor for the default instance.
   always @(negedge clk) begin
      if (!rst_n) begin
         low_len = 0;
      end else begin
         if (b1.a_gnt || b1.b_gnt) begin
            check("gnt_onehot", {31'b0, b1.a_gnt & b1.b_gnt}, 0);
            if (gnt_q.size() == 0) begin
               check("gnt_unexpected", 1, 0);
            end else begin
               cur = gnt_q.pop_front();
               check("gnt_owner", {31'b0, b1.b_gnt}, {31'b0, cur.owner});
               check("setup_ceb", {31'b0, b1.CEb}, 1);
               check("setup_addr", {26'b0, b1.reg_addr}, {26'b0, cur.addr});
               check("setup_rwb", {31'b0, b1.RWb}, {31'b0, cur.rw});
               check("setup_wdata", {24'b0, b1.bus_wdata}, cur.rw ? 32'h0 : {24'b0, cur.wdata});
            end
         end
         if (!b1.CEb) begin
            low_len++;
            check("strobe_addr", {26'b0, b1.reg_addr}, {26'b0, cur.addr});
            check("strobe_rwb", {31'b0, b1.RWb}, {31'b0, cur.rw});
            check("strobe_wdata", {24'b0, b1.bus_wdata}, cur.rw ? 32'h0 : {24'b0, cur.wdata});
         end else if (low_len != 0) begin
            check("strobe_len", low_len, 2);
            low_len = 0;
         end
         if (!b1.busy) check("idle_rwb_ceb", {30'b0, b1.RWb, b1.CEb}, 3);
         if (b1.a_rvalid || b1.b_rvalid) begin
            check("rvalid_onehot", {31'b0, b1.a_rvalid & b1.b_rvalid}, 0);
            if (rd_q.size() == 0) begin
               check("rvalid_unexpected", 1, 0);
            end else begin
               rd_exp = rd_q.pop_front();
               check("rvalid_owner", {31'b0, b1.b_rvalid}, {31'b0, rd_exp.owner});
               check("rvalid_rdata", {24'b0, b1.rdata}, {24'b0, rd_exp.data});
            end
         end
      end
   end

   // Pulse-width monitor for the STROBE_CYC=3 / RECOVER_CYC=2 instance.
   always @(negedge clk) begin
      if (!rst_n) begin
         low2    = 0;
         gap2    = 0;
         pulses2 = 0;
      end else if (!b2.CEb) begin
         if (low2 == 0 && pulses2 > 0) check("p2_gap", gap2, 3);
         low2++;
         gap2 = 0;
         check("p2_addr", {26'b0, b2.reg_addr}, 32'h3F);
         check("p2_wdata", {24'b0, b2.bus_wdata}, 32'h81);
         check("p2_rwb", {31'b0, b2.RWb}, 0);
      end else begin
         if (low2 != 0) begin
            check("p2_low", low2, 3);
            pulses2++;
            low2 = 0;
         end
         gap2++;
      end
   end

   initial begin
      int waited;
      int last_cyc;
      int na, nb, ng;

      // Reset with random requester inputs.
      b1.a_req = 1'($urandom); b1.a_rw = 1'($urandom);
      b1.a_addr = 6'($urandom); b1.a_wdata = 8'($urandom);
      b1.b_req = 1'($urandom); b1.b_rw = 1'($urandom);
      b1.b_addr = 6'($urandom); b1.b_wdata = 8'($urandom);
      b2.a_req = 1'b0; b2.a_rw = 1'b0; b2.a_addr = '0; b2.a_wdata = '0;
      b2.b_req = 1'b0; b2.b_rw = 1'b0; b2.b_addr = '0; b2.b_wdata = '0;
      rst_n = 1'b0;
      tick();
      tick();
      check("rst_ceb", {31'b0, b1.CEb}, 1);
      check("rst_rwb", {31'b0, b1.RWb}, 1);
      check("rst_addr", {26'b0, b1.reg_addr}, 0);
      check("rst_wdata", {24'b0, b1.bus_wdata}, 0);
      check("rst_rdata", {24'b0, b1.rdata}, 0);
      check("rst_busy", {31'b0, b1.busy}, 0);
      check("rst_pulses", {28'b0, b1.a_gnt, b1.b_gnt, b1.a_rvalid, b1.b_rvalid}, 0);
      b1.a_req = 1'b0;
      b1.b_req = 1'b0;
      rst_n = 1'b1;
      tick();

      // Single write from A; this is cycle 0.
      b1.a_rw = 1'b0; b1.a_addr = 6'h2A; b1.a_wdata = 8'h5C; b1.a_req = 1'b1;
      push_gnt(1'b0, 1'b0, 6'h2A, 8'h5C);
      tick();
      check("w_gnt_c1", {31'b0, b1.a_gnt}, 1);
      check("w_busy_c1", {31'b0, b1.busy}, 1);
      b1.a_req = 1'b0;
      tick();
      check("w_ceb_c2", {31'b0, b1.CEb}, 0);
      tick();
      check("w_ceb_c3", {31'b0, b1.CEb}, 0);
      tick();
      check("w_ceb_c4", {31'b0, b1.CEb}, 1);
      check("w_busy_c4", {31'b0, b1.busy}, 1);
      check("w_rvalid_c4", {30'b0, b1.a_rvalid, b1.b_rvalid}, 0);
      tick();
      check("w_busy_c5", {31'b0, b1.busy}, 0);
      check("w_idle_addr", {26'b0, b1.reg_addr}, 32'h2A);
      check("w_idle_wdata", {24'b0, b1.bus_wdata}, 32'h5C);

      // Single read from B.
      b1.b_rw = 1'b1; b1.b_addr = 6'h07; b1.b_wdata = 8'hFF; b1.b_req = 1'b1;
      push_gnt(1'b1, 1'b1, 6'h07, 8'h00);
      push_rd(1'b1, 8'hA5);
      tick();
      check("r_gnt_c1", {30'b0, b1.a_gnt, b1.b_gnt}, 1);
      b1.b_req = 1'b0;
      tick();
      tick();
      check("r_ceb_c3", {31'b0, b1.CEb}, 0);
      tick();
      check("r_rvalid_c4", {30'b0, b1.a_rvalid, b1.b_rvalid}, 1);
      check("r_rdata_c4", {24'b0, b1.rdata}, 32'hA5);
      tick();
      check("r_rdata_hold", {24'b0, b1.rdata}, 32'hA5);
      check("r_busy_c5", {31'b0, b1.busy}, 0);

      // Contention: A writes, B reads, both held until their third grant.
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      b1.a_rw = 1'b0; b1.a_addr = 6'h11; b1.a_wdata = 8'h3C;
      b1.b_rw = 1'b1; b1.b_addr = 6'h07;
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) begin
            push_gnt(1'b0, 1'b0, 6'h11, 8'h3C);
         end else begin
            push_gnt(1'b1, 1'b1, 6'h07, 8'h00);
            push_rd(1'b1, 8'hA5);
         end
      end
      b1.a_req = 1'b1;
      b1.b_req = 1'b1;
      na = 0;
      nb = 0;
      last_cyc = 0;
      for (int k = 0; k < 6; k++) begin
         waited = 0;
         do begin
            tick();
            waited++;
         end while (!(b1.a_gnt || b1.b_gnt) && waited < 10);
         if (!(b1.a_gnt || b1.b_gnt)) begin
            check("cont_gnt_timeout", 0, 1);
            break;
         end
         if (k > 0) check("cont_gnt_spacing", cyc - last_cyc, 4);
         last_cyc = cyc;
         if (b1.a_gnt) begin
            na++;
            if (na == 3) b1.a_req = 1'b0;
         end
         if (b1.b_gnt) begin
            nb++;
            if (nb == 3) b1.b_req = 1'b0;
         end
      end
      waited = 0;
      while (b1.busy && waited < 20) begin
         tick();
         waited++;
      end
      check("cont_drained", {31'b0, b1.busy}, 0);
      check("cont_a_grants", na, 3);
      check("cont_b_grants", nb, 3);
      check("cont_gnt_q_empty", gnt_q.size(), 0);
      check("cont_rd_q_empty", rd_q.size(), 0);

      // Reset during the second STROBE cycle of a B read.
      b1.b_rw = 1'b1; b1.b_addr = 6'h07; b1.b_req = 1'b1;
      push_gnt(1'b1, 1'b1, 6'h07, 8'h00);
      tick();
      check("mr_gnt_c1", {31'b0, b1.b_gnt}, 1);
      b1.b_req = 1'b0;
      tick();
      check("mr_ceb_c2", {31'b0, b1.CEb}, 0);
      tick();
      check("mr_ceb_c3", {31'b0, b1.CEb}, 0);
      rst_n = 1'b0;
      tick();
      check("mr_ceb_c4", {31'b0, b1.CEb}, 1);
      check("mr_rvalid_c4", {30'b0, b1.a_rvalid, b1.b_rvalid}, 0);
      check("mr_rdata_c4", {24'b0, b1.rdata}, 0);
      check("mr_busy_c4", {31'b0, b1.busy}, 0);
      rst_n = 1'b1;
      tick();

      // Next request after the aborted one: A read.
      b1.a_rw = 1'b1; b1.a_addr = 6'h15; b1.a_req = 1'b1;
      push_gnt(1'b0, 1'b1, 6'h15, 8'h00);
      push_rd(1'b0, 8'hB7);
      tick();
      check("ar_gnt_c1", {30'b0, b1.a_gnt, b1.b_gnt}, 2);
      b1.a_req = 1'b0;
      tick();
      tick();
      tick();
      check("ar_rvalid_c4", {30'b0, b1.a_rvalid, b1.b_rvalid}, 2);
      check("ar_rdata_c4", {24'b0, b1.rdata}, 32'hB7);
      tick();

      // Ten back-to-back writes on the STROBE_CYC=3 / RECOVER_CYC=2 instance.
      b2.a_rw = 1'b0; b2.a_addr = 6'h3F; b2.a_wdata = 8'h81; b2.a_req = 1'b1;
      ng = 0;
      last_cyc = 0;
      for (int k = 0; k < 10; k++) begin
         waited = 0;
         do begin
            tick();
            waited++;
         end while (!b2.a_gnt && waited < 20);
         if (!b2.a_gnt) begin
            check("p2_gnt_timeout", 0, 1);
            break;
         end
         if (k > 0) check("p2_gnt_spacing", cyc - last_cyc, 6);
         last_cyc = cyc;
         ng++;
         if (k == 9) b2.a_req = 1'b0;
      end
      repeat (12) tick();
      check("p2_grants", ng, 10);
      check("p2_pulses", pulses2, 10);
      check("p2_idle", {31'b0, b2.busy}, 0);
      check("final_gnt_q_empty", gnt_q.size(), 0);
      check("final_rd_q_empty", rd_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
